// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte/write-enable push bus from the memory-access stage
// Signals:
//   uart    : byte to transmit, meaningful only while uart_we is high
//   uart_we : single-cycle push strobe
// Modports: master (memory-access stage drives), slave (uart_tx_fifo receives)
interface uart_tx_fifo_if;
    logic [7:0] uart;
    logic       uart_we;

    modport master (output uart, output uart_we);
    modport slave  (input  uart, input  uart_we);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8N1 LSB first (8E1 with UART_TX_PARITY_EN)
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
// Ports:
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   bus            : uart_tx_fifo_if.slave push bus (uart byte, uart_we strobe)
//   i_overflow_clr : synchronous clear of the sticky overflow flag
//   o_uart_tx      : serial line, idle high
//   o_tx_busy      : FIFO non-empty or frame in flight
//   o_fifo_count   : bytes queued, excluding the byte in the shifter (0..DEPTH)
//   o_overflow     : sticky, a push was dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_fifo_if.slave            bus,
    input  logic                     i_overflow_clr,
    output logic                     o_uart_tx,
    output logic                     o_tx_busy,
    output logic [FIFO_DEPTH_LOG2:0] o_fifo_count,
    output logic                     o_overflow
);
    localparam int                     DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]            BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [15:0]                  r_baud;
    logic [2:0]                   r_bit_idx;
    logic [7:0]                   r_shift;
    logic [7:0]                   r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]     r_count;
    logic                         r_overflow;
`ifdef UART_TX_PARITY_EN
    logic                         r_parity;
`endif

    logic w_bit_done;
    logic w_not_empty;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_tx;

    assign w_bit_done  = (r_baud == BAUD_LAST);
    assign w_not_empty = (r_count != '0);
    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
    assign w_full      = (r_count == COUNT_FULL);
    assign w_push      = bus.uart_we && !w_full;
    assign w_drop      = bus.uart_we && w_full;

    // Next state, pop request and line level. The line is decoded from
    // registered state only, so reset forces it high without waiting for a clock.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_done) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_done && r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx = r_parity;
                if (w_bit_done) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (w_bit_done) begin
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_baud    <= '0;
                r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^r_mem[r_rd_ptr];
`endif
            end else if (r_state != S_IDLE) begin
                if (w_bit_done) begin
                    r_baud <= '0;
                    if (r_state == S_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.uart;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)              r_overflow <= 1'b1;
            else if (i_overflow_clr) r_overflow <= 1'b0;
        end
    end

    assign o_uart_tx    = w_tx;
    assign o_tx_busy    = (r_state != S_IDLE) || w_not_empty;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-schedule reference model
module tb_uart_tx_fifo;
    localparam int C     = 4;
    localparam int LOG2  = 2;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          tx;
    logic          busy;
    logic          ovf;
    logic [LOG2:0] cnt;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_overflow_clr (overflow_clr),
        .o_uart_tx      (tx),
        .o_tx_busy      (busy),
        .o_fifo_count   (cnt),
        .o_overflow     (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: every accepted byte has a push edge p and a frame start edge s.
    int         m_p[$];
    int         m_s[$];
    logic [7:0] m_d[$];
    bit         m_ovf = 1'b0;
    logic [7:0] rx_q[$];

    function automatic int exp_count(int k);
        int n = 0;
        for (int i = 0; i < m_p.size(); i++)
            if (m_p[i] <= k && m_s[i] > k) n++;
        return n;
    endfunction

    function automatic bit exp_busy(int k);
        for (int i = 0; i < m_p.size(); i++)
            if (m_p[i] <= k && k < m_s[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_line(int k);
        int b;
        for (int i = 0; i < m_s.size(); i++) begin
            if (m_s[i] <= k && k < m_s[i] + FRAME) begin
                b = (k - m_s[i]) / C;
                if (b == 0) return 1'b0;
                if (b <= 8) return m_d[i][b-1];
                if (b == NBITS - 1) return 1'b1;
                return ^m_d[i];
            end
        end
        return 1'b1;
    endfunction

    // Receiver: frames start on a low line while idle, bits sampled mid-bit.
    bit         rx_in = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = 8'h00;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_in <= 1'b0;
        end else if (!rx_in) begin
            if (tx == 1'b0) begin
                rx_in <= 1'b1;
                rx_t  <= 1;
                rx_sh <= 8'h00;
            end
        end else begin
            if (rx_t % C == C / 2 && rx_t / C >= 1 && rx_t / C <= 8) rx_sh[rx_t/C-1] <= tx;
            if (rx_t == FRAME - 1) begin
                rx_in <= 1'b0;
                rx_q.push_back(rx_sh);
            end
            rx_t <= rx_t + 1;
        end
    end

    // Drive one edge worth of inputs (called at a falling edge), update the
    // model for that edge, and return at the next falling edge.
    task automatic drive(input bit we, input logic [7:0] d, input bit clr);
        int k;
        int start;
        k = cyc + 1;
        bus.uart_we  = we;
        bus.uart     = we ? d : 8'hxx;
        overflow_clr = clr;
        if (we && exp_count(k - 1) < DEPTH) begin
            start = k + 1;
            if (m_s.size() > 0 && m_s[$] + FRAME > start) start = m_s[$] + FRAME;
            m_p.push_back(k);
            m_s.push_back(start);
            m_d.push_back(d);
        end else if (we) begin
            m_ovf = 1'b1;
        end
        if (!(we && exp_count(k - 1) >= DEPTH) && clr) m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.uart_we  = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic model_clear();
        m_p.delete();
        m_s.delete();
        m_d.delete();
        rx_q.delete();
    endtask

    task automatic settle();
        int i;
        for (i = 0; i < 1000 && (exp_busy(cyc) || busy); i++) drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL settle_timeout busy=%0b required=0", busy); end
    endtask

    task automatic test_reset();
        bus.uart_we = 1'b0;
        bus.uart    = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        m_ovf = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            n_cmp++; if (tx !== 1'b1)  begin n_bad++; $display("FAIL reset_tx cyc=%0d got=%0b want=1", i, tx); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy cyc=%0d got=%0b want=0", i, busy); end
            n_cmp++; if (cnt !== '0)    begin n_bad++; $display("FAIL reset_count cyc=%0d got=%0d want=0", i, cnt); end
            n_cmp++; if (ovf !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf cyc=%0d got=%0b want=0", i, ovf); end
        end
    endtask

    task automatic test_single_byte();
        bit seq[11];
`ifdef UART_TX_PARITY_EN
        seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        settle(); model_clear();
        drive(1'b1, 8'hA5, 1'b0);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_push_edge_tx got=%0b want=1", tx); end
        n_cmp++; if (cnt !== 3'd1) begin n_bad++; $display("FAIL single_push_edge_count got=%0d want=1", cnt); end
        for (int i = 1; i <= FRAME + 4; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            n_cmp++; if (tx !== exp_line(cyc)) begin n_bad++; $display("FAIL single_line i=%0d got=%0b want=%0b", i, tx, exp_line(cyc)); end
            if ((i - 1) % C == 0 && i <= FRAME) begin
                n_cmp++; if (tx !== seq[(i-1)/C]) begin n_bad++; $display("FAIL single_seq bit=%0d got=%0b want=%0b", (i-1)/C, tx, seq[(i-1)/C]); end
            end
            if (i == FRAME) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_last got=%0b want=1", busy); end
            end
            if (i == FRAME + 1) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop got=%0b want=0", busy); end
            end
        end
        n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_rx frames=%0d want=1 byte A5", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        settle(); model_clear();
        for (int b = 1; b <= 3; b++) begin
            drive(1'b1, 8'(b), 1'b0);
            if (cnt > peak) peak = cnt;
        end
        for (int i = 0; i < 3 * FRAME + 6; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            if (cnt > peak) peak = cnt;
            n_cmp++; if (tx !== exp_line(cyc)) begin n_bad++; $display("FAIL b2b_line i=%0d got=%0b want=%0b", i, tx, exp_line(cyc)); end
            n_cmp++; if (busy !== exp_busy(cyc)) begin n_bad++; $display("FAIL b2b_busy i=%0d got=%0b want=%0b", i, busy, exp_busy(cyc)); end
        end
        n_cmp++; if (peak != 2) begin n_bad++; $display("FAIL b2b_peak got=%0d want=2", peak); end
        n_cmp++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL b2b_frames got=%0d want=3", rx_q.size()); end
        for (int b = 0; b < 3 && b < rx_q.size(); b++) begin
            n_cmp++; if (rx_q[b] !== 8'(b + 1)) begin n_bad++; $display("FAIL b2b_byte idx=%0d got=%02h want=%02h", b, rx_q[b], b + 1); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] sent[5];
        settle(); model_clear();
        for (int b = 0; b < 5; b++) begin
            sent[b] = 8'($urandom);
            drive(1'b1, sent[b], 1'b0);
        end
        n_cmp++; if (cnt !== 3'd4) begin n_bad++; $display("FAIL ovf_full_count got=%0d want=4", cnt); end
        drive(1'b1, 8'hEE, 1'b0);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%0b want=1", ovf); end
        n_cmp++; if (cnt !== 3'd4) begin n_bad++; $display("FAIL ovf_drop_count got=%0d want=4", cnt); end
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%0b want=0", ovf); end
        drive(1'b1, 8'hDD, 1'b1);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set_beats_clear got=%0b want=1", ovf); end
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL ovf_clear2 got=%0b want=%0b", ovf, m_ovf); end
        for (int i = 0; i < 5 * FRAME + 6; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            n_cmp++; if (tx !== exp_line(cyc)) begin n_bad++; $display("FAIL ovf_line i=%0d got=%0b want=%0b", i, tx, exp_line(cyc)); end
            n_cmp++; if (cnt !== exp_count(cyc)) begin n_bad++; $display("FAIL ovf_count i=%0d got=%0d want=%0d", i, cnt, exp_count(cyc)); end
        end
        n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL ovf_frames got=%0d want=5", rx_q.size()); end
        for (int b = 0; b < 5 && b < rx_q.size(); b++) begin
            n_cmp++; if (rx_q[b] !== sent[b]) begin n_bad++; $display("FAIL ovf_byte idx=%0d got=%02h want=%02h", b, rx_q[b], sent[b]); end
        end
    endtask

    task automatic test_midframe_reset();
        int start;
        settle(); model_clear();
        drive(1'b1, 8'h3C, 1'b0);
        start = cyc + 1;
        drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'($urandom), 1'b0);
        while (cyc < start + 17) drive(1'b0, 8'h00, 1'b0);
        n_cmp++; if (cnt !== 3'd2) begin n_bad++; $display("FAIL mid_pre_count got=%0d want=2", cnt); end
        n_cmp++; if (tx !== exp_line(cyc)) begin n_bad++; $display("FAIL mid_pre_line got=%0b want=%0b", tx, exp_line(cyc)); end
        #2 rst_n = 1'b0;
        model_clear();
        m_ovf = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_async_tx got=%0b want=1", tx); end
        n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL mid_async_count got=%0d want=0", cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy got=%0b want=0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_after i=%0d tx=%0b busy=%0b want tx=1 busy=0", i, tx, busy); end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL mid_frames got=%0d want=0", rx_q.size()); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes[2];
        bit         want[2];
        bytes = '{8'h07, 8'h03};
        want  = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            settle(); model_clear();
            drive(1'b1, bytes[t], 1'b0);
            for (int i = 1; i <= FRAME + 1; i++) begin
                drive(1'b0, 8'h00, 1'b0);
                if (i == 9 * C + 2) begin
                    n_cmp++; if (tx !== want[t]) begin n_bad++; $display("FAIL parity_bit byte=%02h got=%0b want=%0b", bytes[t], tx, want[t]); end
                end
                if (i == FRAME + 1) begin
                    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL parity_len byte=%02h busy=%0b want=0", bytes[t], busy); end
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        settle(); model_clear();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 5);
            n_cmp++; if (tx !== exp_line(cyc)) begin n_bad++; $display("FAIL rand_line i=%0d got=%0b want=%0b", i, tx, exp_line(cyc)); end
            n_cmp++; if (cnt !== exp_count(cyc)) begin n_bad++; $display("FAIL rand_count i=%0d got=%0d want=%0d", i, cnt, exp_count(cyc)); end
            n_cmp++; if (busy !== exp_busy(cyc)) begin n_bad++; $display("FAIL rand_busy i=%0d got=%0b want=%0b", i, busy, exp_busy(cyc)); end
            n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL rand_ovf i=%0d got=%0b want=%0b", i, ovf, m_ovf); end
        end
        settle();
        n_cmp++; if (rx_q.size() != m_d.size()) begin n_bad++; $display("FAIL rand_frames got=%0d want=%0d", rx_q.size(), m_d.size()); end
        for (int b = 0; b < m_d.size() && b < rx_q.size(); b++) begin
            n_cmp++; if (rx_q[b] !== m_d[b]) begin n_bad++; $display("FAIL rand_byte idx=%0d got=%02h want=%02h", b, rx_q[b], m_d[b]); end
        end
    endtask

    initial begin
        bus.uart_we = 1'b0;
        bus.uart    = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_midframe_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
